traffic_safety_monitor: RTL and testbench
=========================================

// Module: traffic_safety_monitor
// PURPOSE
//  Downstream stage of the traffic sequencer. Registers its car/walker lamp codes, checks them
//  every cycle against safety rules, and forwards them to the lamp drivers.
//  On any violation it latches a fault code and overrides the lamps with a car-yellow flash
//  and walker-off pattern until the fault is cleared. This ensures an illegal code never reaches a lamp.
// PARAMETERS
//  YELLOW_LEN  2   required length of every car-yellow run, in cycles
//  MAX_PHASE   40  max consecutive cycles any one car code may persist while running
//  FLASH_HALF  4   cycles per half-period of the fault flash
//  WALK_TOTAL  20  walker green+flash window length, in cycles (countdown option only)
// PORTS
//  clk               in   1  single clock, rising edge
//  reset             in   1  synchronous, active-high reset
//  i_start           in   1  sequencer run enable, same signal that drives the sequencer
//  i_car_traffic     in   4  car code: 1000 red, 0100 yellow, 0010 left, 0001 green, 0000 none
//  i_walker_traffic  in   2  walker code: 10 red, 01 green, 00 none
//  i_fault_clr       in   1  fault clear pulse
//  o_car_lamp        out  4  registered car lamp drive, same encoding
//  o_walker_lamp     out  2  registered walker lamp drive, same encoding
//  o_fault           out  1  high while in ST_FAULT
//  o_fault_code      out  3  latched code: 0 none, 1 ILL_CAR, 2 ILL_WALK, 3 CONFLICT, 4 YEL_LEN, 5 STUCK
//  o_walk_count      out  7  walker cycles remaining (only with TRAFFIC_MON_COUNTDOWN_EN)
// BEHAVIOUR
//  - Reset: state ST_IDLE; all outputs 0; counters 0. Reset mid-fault drops the fault.
//  - States:
//    - ST_IDLE: outputs NONE/NONE. Go to ST_RUN on i_start=1, which is also checked that same cycle.
//    - ST_RUN: the cycle-N inputs are checked; if clean, they appear on the lamps at N+1 (1-cycle latency).
//      i_start=0 returns to ST_IDLE next cycle with lamps 0000/00 and counters cleared.
//    - ST_FAULT: entered at the edge where a check fails. The failing input is never forwarded.
//      o_fault=1 and o_fault_code are valid from N+1.
//  - Checks (ST_RUN, and the ST_IDLE cycle with i_start=1):
//    - ILL_CAR: car code not exactly one of the four lamp codes.
//    - ILL_WALK: walker code is 11.
//    - CONFLICT: walker green while car is not red.
//    - YEL_LEN: a yellow run ends with length != YELLOW_LEN.
//    - STUCK: the same car code has been held for MAX_PHASE+1 consecutive cycles.
//    - Run length starts at 1 on the first i_start cycle and on every car-code change.
//    - The run counter is clog2(MAX_PHASE+2) bits wide and saturates.
//    - Several checks failing in one cycle: the lowest code wins.
//  - ST_FAULT outputs:
//    - walker 00.
//    - car alternates 0100 for FLASH_HALF cycles, then 0000 for FLASH_HALF cycles, starting with 0100 at N+1.
//    - Inputs are ignored and o_fault_code is held.
//  - Clear: i_fault_clr=1 with i_start=0 in ST_FAULT goes to ST_IDLE next cycle, with fault and code set to 0.
//    i_fault_clr while i_start=1, or in any other state, is ignored.
// CONFIGURATION
//  TRAFFIC_MON_COUNTDOWN_EN defined:
//   - Walker code going red->green in ST_RUN loads o_walk_count=WALK_TOTAL-1.
//   - It then decrements each cycle and holds at 0.
//   - It is cleared on ST_IDLE, ST_FAULT, or walker red.
//   - It is aligned with o_walker_lamp.
//  Not defined: o_walk_count is tied to 0 and no counter logic exists.
// STRUCTURE
//  - traffic_pkg: lamp code constants, fault code localparams, state encoding.
//  - Sub-module traffic_flash_gen (enable, FLASH_HALF) produces the flash phase bit.
//  - Everything else stays in this module.
// TESTING
//  1. Drive the normal sequence: green x20, yellow x2, left x10, yellow x2, red x34 (walker green in the
//     red window), repeated 3 periods -> lamps = inputs delayed 1 cycle, o_fault stays 0.
//  2. Hold car yellow for 3 cycles -> at the 4th input cycle (green) the lamps do not show green,
//     o_fault=1, code=4, car lamp 0100 for 4 cycles then 0000 for 4 cycles.
//  3. Walker 01 while car 0001 -> next cycle o_fault=1, code=3, walker lamp 00.
//     In the same cycle also drive car 0011 -> code=1 (priority).
//  4. Hold car red for 41 cycles -> fault code=5 after the 41st cycle. Red for exactly 40 cycles -> no fault.
//  5. In fault: pulse i_fault_clr with i_start=1 -> ignored. Drop i_start, then pulse i_fault_clr -> ST_IDLE,
//     outputs 0. Assert reset mid-fault -> all outputs 0 next cycle.
//  6. With TRAFFIC_MON_COUNTDOWN_EN: at the walker red->green edge o_walk_count=19, then 18, 17 ... 0, then held.
//     Without the macro it is always 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic safety monitor: lamp codes, fault codes,
// FSM state encoding and a helper that recognises a legal car lamp code.
package traffic_pkg;

   localparam logic [3:0] CAR_NONE  = 4'b0000;
   localparam logic [3:0] CAR_GREEN = 4'b0001;
   localparam logic [3:0] CAR_LEFT  = 4'b0010;
   localparam logic [3:0] CAR_YEL   = 4'b0100;
   localparam logic [3:0] CAR_RED   = 4'b1000;

   localparam logic [1:0] WALK_NONE  = 2'b00;
   localparam logic [1:0] WALK_GREEN = 2'b01;
   localparam logic [1:0] WALK_RED   = 2'b10;
   localparam logic [1:0] WALK_ILL   = 2'b11;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_ILL_CAR  = 3'd1;
   localparam logic [2:0] FC_ILL_WALK = 3'd2;
   localparam logic [2:0] FC_CONFLICT = 3'd3;
   localparam logic [2:0] FC_YEL_LEN  = 3'd4;
   localparam logic [2:0] FC_STUCK    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // A car code is legal only if it is exactly one of the four lamp codes.
   function automatic logic car_legal(input logic [3:0] car);
      return (car == CAR_GREEN) || (car == CAR_LEFT) ||
             (car == CAR_YEL)   || (car == CAR_RED);
   endfunction

endpackage

// File: rtl/traffic_safety_monitor_if.sv
// Bundle between the traffic sequencer side and the safety monitor.
//   i_start, i_car_traffic, i_walker_traffic, i_fault_clr : sequencer -> monitor
//   o_car_lamp, o_walker_lamp, o_fault, o_fault_code,
//   o_walk_count                                           : monitor -> lamp drivers
// master: the sequencer/driver side; slave: the monitor.
interface traffic_safety_monitor_if;

   logic       i_start;
   logic [3:0] i_car_traffic;
   logic [1:0] i_walker_traffic;
   logic       i_fault_clr;
   logic [3:0] o_car_lamp;
   logic [1:0] o_walker_lamp;
   logic       o_fault;
   logic [2:0] o_fault_code;
   logic [6:0] o_walk_count;

   modport master (
      output i_start, i_car_traffic, i_walker_traffic, i_fault_clr,
      input  o_car_lamp, o_walker_lamp, o_fault, o_fault_code, o_walk_count
   );

   modport slave (
      input  i_start, i_car_traffic, i_walker_traffic, i_fault_clr,
      output o_car_lamp, o_walker_lamp, o_fault, o_fault_code, o_walk_count
   );

endinterface

// File: rtl/traffic_flash_gen.sv
// Fault flash phase generator.
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset
//   enable   in  flash running; low parks the generator in its "on" phase
//   flash_on out registered phase: 1 for FLASH_HALF cycles, 0 for FLASH_HALF cycles, repeat
module traffic_flash_gen #(
   parameter int FLASH_HALF = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic flash_on
);

   localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         cnt      <= '0;
         flash_on <= 1'b1;
      end else if (cnt == CW'(FLASH_HALF - 1)) begin
         cnt      <= '0;
         flash_on <= ~flash_on;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety monitor between the traffic sequencer and the lamp drivers.
// Registers the car/walker codes, checks them every cycle and forwards only
// clean codes. Any violation latches a fault code and replaces the lamps with a
// car-yellow flash / walker-off pattern until cleared.
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave side of traffic_safety_monitor_if (inputs from the sequencer,
//          lamp/fault outputs)
// Optional macro TRAFFIC_MON_COUNTDOWN_EN adds the walker countdown on
// o_walk_count; without it o_walk_count is constant 0.
//
// state    | meaning
// ST_IDLE  | sequencer stopped, lamps off; i_start=1 is checked and starts a run
// ST_RUN   | inputs checked each cycle, clean codes forwarded with 1-cycle latency
// ST_FAULT | fault latched, lamps show car-yellow flash / walker off
module traffic_safety_monitor
   import traffic_pkg::*;
#(
   parameter int YELLOW_LEN = 2,
   parameter int MAX_PHASE  = 40,
   parameter int FLASH_HALF = 4,
   parameter int WALK_TOTAL = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   traffic_safety_monitor_if.slave  bus
);

   localparam int RW = $clog2(MAX_PHASE + 2);

   state_t        state_q, state_d;
   logic [3:0]    car_q, car_d;
   logic [1:0]    walk_q, walk_d;
   logic [2:0]    code_q, code_d;
   logic [RW-1:0] run_len, run_d, run_next;
   logic [2:0]    fc;
   logic          fwd;
   logic          flash_on;

   logic [3:0] car;
   logic [1:0] wk;
   assign car = bus.i_car_traffic;
   assign wk  = bus.i_walker_traffic;

   // Outside ST_RUN car_q is 0, so a run always restarts at 1.
   always_comb begin
      if (state_q == ST_RUN && car == car_q)
         run_next = (run_len == RW'(MAX_PHASE + 1)) ? run_len : run_len + 1'b1;
      else
         run_next = RW'(1);
   end

   // Lowest code wins, so test in ascending order. The last forwarded car
   // code (car_q) is the previous cycle's input while running.
   always_comb begin
      fc = FC_NONE;
      if (!car_legal(car))
         fc = FC_ILL_CAR;
      else if (wk == WALK_ILL)
         fc = FC_ILL_WALK;
      else if (wk == WALK_GREEN && car != CAR_RED)
         fc = FC_CONFLICT;
      else if (state_q == ST_RUN && car_q == CAR_YEL && car != CAR_YEL &&
               run_len != RW'(YELLOW_LEN))
         fc = FC_YEL_LEN;
      else if (run_next == RW'(MAX_PHASE + 1))
         fc = FC_STUCK;
   end

   always_comb begin
      state_d = state_q;
      car_d   = car_q;
      walk_d  = walk_q;
      code_d  = code_q;
      run_d   = run_len;
      fwd     = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            car_d  = CAR_NONE;
            walk_d = WALK_NONE;
            run_d  = '0;
            if (!bus.i_start) begin
               state_d = ST_IDLE;
            end else if (fc != FC_NONE) begin
               state_d = ST_FAULT;
               code_d  = fc;
            end else begin
               state_d = ST_RUN;
               car_d   = car;
               walk_d  = wk;
               run_d   = run_next;
               fwd     = 1'b1;
            end
         end
         ST_FAULT: begin
            if (bus.i_fault_clr && !bus.i_start) begin
               state_d = ST_IDLE;
               code_d  = FC_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         car_q   <= CAR_NONE;
         walk_q  <= WALK_NONE;
         code_q  <= FC_NONE;
         run_len <= '0;
      end else begin
         state_q <= state_d;
         car_q   <= car_d;
         walk_q  <= walk_d;
         code_q  <= code_d;
         run_len <= run_d;
      end
   end

   traffic_flash_gen #(
      .FLASH_HALF (FLASH_HALF)
   ) u_flash (
      .clk      (clk),
      .reset    (reset),
      .enable   (state_q == ST_FAULT),
      .flash_on (flash_on)
   );

   // In fault the car lamp is a pure select between two registered sources
   // (state and flash phase); car_q is held at 0 there.
   assign bus.o_car_lamp    = (state_q == ST_FAULT) ? (flash_on ? CAR_YEL : CAR_NONE) : car_q;
   assign bus.o_walker_lamp = walk_q;
   assign bus.o_fault       = (state_q == ST_FAULT);
   assign bus.o_fault_code  = code_q;

`ifdef TRAFFIC_MON_COUNTDOWN_EN
   logic [6:0] walk_cnt;

   // Updated on the same edge as walk_q so the count lines up with the lamp.
   always_ff @(posedge clk) begin
      if (reset || !fwd)
         walk_cnt <= '0;
      else if (state_q == ST_RUN && walk_q == WALK_RED && wk == WALK_GREEN)
         walk_cnt <= 7'(WALK_TOTAL - 1);
      else if (wk == WALK_RED)
         walk_cnt <= '0;
      else if (walk_cnt != '0)
         walk_cnt <= walk_cnt - 1'b1;
   end

   assign bus.o_walk_count = walk_cnt;
`else
   assign bus.o_walk_count = '0;
`endif

endmodule

// File: tb/tb_traffic_safety_monitor.sv
module tb_traffic_safety_monitor;
   import traffic_pkg::*;

   typedef struct packed {
      logic [3:0] car;
      logic [1:0] wk;
      logic       f;
      logic [2:0] code;
      logic [6:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;
   obs_t  exp_q[$];
   string tag_q[$];

   traffic_safety_monitor_if bus();

   traffic_safety_monitor dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [3:0] car, input logic [1:0] wk, input logic f,
                               input logic [2:0] code, input logic [6:0] cnt);
      obs_t o;
      o.car = car; o.wk = wk; o.f = f; o.code = code; o.cnt = cnt;
      return o;
   endfunction

   // Expected flash car code k cycles after fault entry.
   function automatic logic [3:0] flash_car(input int k);
      return (((k / 4) % 2) == 0) ? CAR_YEL : CAR_NONE;
   endfunction

   task automatic check_out();
      obs_t  o, e;
      string t;
      o = {bus.o_car_lamp, bus.o_walker_lamp, bus.o_fault, bus.o_fault_code, bus.o_walk_count};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h expected <entry>", o);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic clr,
                       input logic [3:0] car, input logic [1:0] wk,
                       input obs_t e, input string tag);
      @(negedge clk);
      reset                = rst;
      bus.i_start          = st;
      bus.i_fault_clr      = clr;
      bus.i_car_traffic    = car;
      bus.i_walker_traffic = wk;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Drive garbage inputs for n cycles in fault; flash index starts at k.
   task automatic fault_hold(input int k, input int n, input logic st, input logic clr,
                             input logic [2:0] code, input string tag, output int k_next);
      for (int i = 0; i < n; i++)
         step(1'b0, st, clr, 4'b0011, WALK_ILL, mk(flash_car(k + i), WALK_NONE, 1'b1, code, 7'd0), tag);
      k_next = k + n;
   endtask

   initial begin
      logic [3:0] car;
      logic [1:0] wk, prev_wk;
      logic [6:0] wc;
      int         k;
      obs_t       zero;
      zero = mk(CAR_NONE, WALK_NONE, 1'b0, FC_NONE, 7'd0);

      bus.i_start = 1'b0; bus.i_fault_clr = 1'b0;
      bus.i_car_traffic = CAR_NONE; bus.i_walker_traffic = WALK_NONE;
      reset = 1'b1;

      step(1'b1, 1'b0, 1'b0, CAR_NONE, WALK_NONE, zero, "reset");
      step(1'b0, 1'b0, 1'b0, CAR_GREEN, WALK_RED, zero, "idle");

      // Normal sequence, 3 periods
      wc = 7'd0; prev_wk = WALK_NONE;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 68; i++) begin
            wk = WALK_RED;
            if (i < 20)      car = CAR_GREEN;
            else if (i < 22) car = CAR_YEL;
            else if (i < 32) car = CAR_LEFT;
            else if (i < 34) car = CAR_YEL;
            else begin
               car = CAR_RED;
               if (i - 34 >= 2 && i - 34 < 30) wk = WALK_GREEN;
            end
`ifdef TRAFFIC_MON_COUNTDOWN_EN
            if (wk == WALK_GREEN && prev_wk == WALK_RED) wc = 7'd19;
            else if (wk == WALK_RED)                     wc = 7'd0;
            else if (wc != 7'd0)                         wc = wc - 7'd1;
`endif
            prev_wk = wk;
            step(1'b0, 1'b1, 1'b0, car, wk, mk(car, wk, 1'b0, FC_NONE, wc), "normal");
         end
      end
      step(1'b0, 1'b0, 1'b0, CAR_RED, WALK_RED, zero, "stop");

      // Yellow held 3 cycles
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, CAR_GREEN, WALK_RED, mk(CAR_GREEN, WALK_RED, 1'b0, FC_NONE, 7'd0), "pre_yel");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, CAR_YEL, WALK_RED, mk(CAR_YEL, WALK_RED, 1'b0, FC_NONE, 7'd0), "yel3");
      step(1'b0, 1'b1, 1'b0, CAR_GREEN, WALK_RED, mk(CAR_YEL, WALK_NONE, 1'b1, FC_YEL_LEN, 7'd0), "yel_len");
      fault_hold(1, 2, 1'b1, 1'b0, FC_YEL_LEN, "flash", k);
      fault_hold(k, 1, 1'b1, 1'b1, FC_YEL_LEN, "clr_ignored", k);
      fault_hold(k, 5, 1'b1, 1'b0, FC_YEL_LEN, "flash", k);
      fault_hold(k, 1, 1'b0, 1'b0, FC_YEL_LEN, "start_drop", k);
      step(1'b0, 1'b0, 1'b1, CAR_NONE, WALK_NONE, zero, "clear");
      step(1'b0, 1'b0, 1'b0, CAR_NONE, WALK_NONE, zero, "idle_after_clear");

      // Conflict
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b1, 1'b0, CAR_RED, WALK_RED, mk(CAR_RED, WALK_RED, 1'b0, FC_NONE, 7'd0), "pre_conf");
      step(1'b0, 1'b1, 1'b0, CAR_GREEN, WALK_GREEN, mk(CAR_YEL, WALK_NONE, 1'b1, FC_CONFLICT, 7'd0), "conflict");
      step(1'b0, 1'b0, 1'b1, CAR_NONE, WALK_NONE, zero, "clear_conf");

      // Priority: illegal car together with conflict, checked on the start cycle
      step(1'b0, 1'b1, 1'b0, 4'b0011, WALK_GREEN, mk(CAR_YEL, WALK_NONE, 1'b1, FC_ILL_CAR, 7'd0), "ill_car_prio");
      step(1'b0, 1'b0, 1'b1, CAR_NONE, WALK_NONE, zero, "clear_ill_car");
      step(1'b0, 1'b1, 1'b0, CAR_RED, WALK_ILL, mk(CAR_YEL, WALK_NONE, 1'b1, FC_ILL_WALK, 7'd0), "ill_walk");
      step(1'b0, 1'b0, 1'b1, CAR_NONE, WALK_NONE, zero, "clear_ill_walk");

      // Stuck boundary: 40 red allowed, 41 red faults
      for (int i = 0; i < 40; i++)
         step(1'b0, 1'b1, 1'b0, CAR_RED, WALK_RED, mk(CAR_RED, WALK_RED, 1'b0, FC_NONE, 7'd0), "red40");
      step(1'b0, 1'b1, 1'b0, CAR_GREEN, WALK_RED, mk(CAR_GREEN, WALK_RED, 1'b0, FC_NONE, 7'd0), "after_red40");
      for (int i = 0; i < 40; i++)
         step(1'b0, 1'b1, 1'b0, CAR_RED, WALK_RED, mk(CAR_RED, WALK_RED, 1'b0, FC_NONE, 7'd0), "red41_pre");
      step(1'b0, 1'b1, 1'b0, CAR_RED, WALK_RED, mk(CAR_YEL, WALK_NONE, 1'b1, FC_STUCK, 7'd0), "stuck");
      fault_hold(1, 5, 1'b1, 1'b0, FC_STUCK, "stuck_flash", k);
      step(1'b1, 1'b1, 1'b0, CAR_RED, WALK_RED, zero, "reset_mid_fault");
      step(1'b0, 1'b0, 1'b0, CAR_RED, WALK_RED, zero, "idle_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
